// File: rtl/fb_controller.sv
// Frame-buffer controller: arbitrates one frame RAM between rasteriser pixel writes
// and a scan-out prefetcher. Optional front/back swapping when FB_DOUBLE_BUFFER_EN is defined.
//
// state   | meaning
// --------+--------------------------------------------------------
// S_IDLE  | no scan-out active, writes own every RAM slot
// S_FETCH | prefetching the current frame into the scan-out FIFO
// S_DONE  | whole frame issued, writes own the RAM until scan_start
module fb_controller #(
  parameter int WIDTH      = 399,
  parameter int HEIGHT     = 240,
  parameter int FIFO_DEPTH = 8,
  parameter int LOW_WATER  = 4
) (
  input  logic        clk,
  input  logic        reset,
  output logic        ready_o,
  input  logic [16:0] drawIndex_i,
  input  logic [8:0]  dataIn_i,
  input  logic        loaded_i,
  output logic [17:0] mem_addr_o,
  output logic [8:0]  mem_wdata_o,
  output logic        mem_we_o,
  output logic        mem_re_o,
  input  logic [8:0]  mem_rdata_i,
  input  logic        scan_start_i,
  input  logic        scan_rd_i,
  output logic [8:0]  scan_data_o,
  output logic        scan_empty_o,
  output logic        underflow_o,
  output logic        front_o
);

  localparam int FRAME = WIDTH * HEIGHT;
  localparam logic [16:0] LAST_IDX = 17'(FRAME - 1);
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int OW = $clog2(FIFO_DEPTH + 1);
  localparam logic [OW:0]   DEPTH_C  = (OW + 1)'(FIFO_DEPTH);
  localparam logic [OW:0]   LOW_C    = (OW + 1)'(LOW_WATER);
  localparam logic [PW-1:0] PTR_LAST = PW'(FIFO_DEPTH - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [16:0]   rd_addr_q, rd_addr_d;
  logic          ready_q, ready_d;
  logic          wr_slot_q;
  logic          inflight_q, inflight_d;
  logic [OW-1:0] occ_q, occ_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [8:0]    fifo_q [FIFO_DEPTH];
  logic          underflow_q;

  logic          buf_rd, buf_wr;
  logic          wr_en, rd_en, push, pop;
  logic [OW:0]   fill_cur, fill_nxt;

  // A reserved slot is consumed even when the pixel index is out of range.
  assign wr_en    = wr_slot_q && !reset && (drawIndex_i <= LAST_IDX);
  assign fill_cur = {1'b0, occ_q} + {{OW{1'b0}}, inflight_q};
  assign rd_en    = (state_q == S_FETCH) && !scan_start_i && !wr_slot_q && !reset &&
                    (fill_cur < DEPTH_C);
  assign push     = inflight_q && !scan_start_i;
  assign pop      = scan_rd_i && (occ_q != '0);

  always_comb begin
    state_d    = state_q;
    rd_addr_d  = rd_addr_q;
    occ_d      = occ_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    inflight_d = rd_en;
    if (scan_start_i) begin
      state_d    = S_FETCH;
      rd_addr_d  = '0;
      occ_d      = '0;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      inflight_d = 1'b0;
    end else begin
      if (rd_en) begin
        rd_addr_d = rd_addr_q + 17'd1;
        if (rd_addr_q == LAST_IDX) state_d = S_DONE;
      end
      if (push) wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PW'(1);
      case ({push, pop})
        2'b10:   occ_d = occ_q + OW'(1);
        2'b01:   occ_d = occ_q - OW'(1);
        default: occ_d = occ_q;
      endcase
    end
    // Throttle the rasteriser on the occupancy the FIFO will have next cycle.
    fill_nxt = {1'b0, occ_d} + {{OW{1'b0}}, inflight_d};
    ready_d  = !((state_d == S_FETCH) && (fill_nxt <= LOW_C));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      rd_addr_q   <= '0;
      ready_q     <= 1'b0;
      wr_slot_q   <= 1'b0;
      inflight_q  <= 1'b0;
      occ_q       <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      underflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      rd_addr_q  <= rd_addr_d;
      ready_q    <= ready_d;
      wr_slot_q  <= ready_q;
      inflight_q <= inflight_d;
      occ_q      <= occ_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      if (scan_rd_i && (occ_q == '0)) underflow_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_ptr_q] <= mem_rdata_i;
  end

`ifdef FB_DOUBLE_BUFFER_EN
  logic front_q, swap_pending_q, loaded_q, loaded_rise;

  assign loaded_rise = loaded_i && !loaded_q;

  // An edge coinciding with scan_start is kept pending for the following frame.
  always_ff @(posedge clk) begin
    if (reset) begin
      front_q        <= 1'b0;
      swap_pending_q <= 1'b0;
      loaded_q       <= 1'b0;
    end else begin
      loaded_q <= loaded_i;
      if (scan_start_i) begin
        if (swap_pending_q) front_q <= ~front_q;
        swap_pending_q <= loaded_rise;
      end else if (loaded_rise) begin
        swap_pending_q <= 1'b1;
      end
    end
  end

  assign buf_rd = front_q;
  assign buf_wr = ~front_q;
`else
  logic unused_loaded;
  assign unused_loaded = loaded_i;
  assign buf_rd = 1'b0;
  assign buf_wr = 1'b0;
`endif

  always_comb begin
    mem_addr_o = '0;
    if (wr_en)      mem_addr_o = {buf_wr, drawIndex_i};
    else if (rd_en) mem_addr_o = {buf_rd, rd_addr_q};
  end

  assign ready_o      = ready_q;
  assign mem_we_o     = wr_en;
  assign mem_re_o     = rd_en;
  assign mem_wdata_o  = wr_en ? dataIn_i : '0;
  assign scan_empty_o = (occ_q == '0);
  assign scan_data_o  = scan_empty_o ? '0 : fifo_q[rd_ptr_q];
  assign underflow_o  = underflow_q;
  assign front_o      = buf_rd;

endmodule
